la_checkpoint_arbiter: RTL and testbench
========================================

Name: la_checkpoint_arbiter

Overview:
- User-project block that shares the 16-bit checkpoint output bus (mprj_io[31:16]) between several on-chip requesters.
- Each requester posts a progress code via a valid/ready handshake; the block grants round-robin and holds each code on the pads for a minimum time so the bench can observe every code.
- The management SoC can force a code through the logic-analyzer probes, overriding arbitration.

Parameters:
- NREQ, 4, number of requesters (2..8).
- CODE_W, 16, checkpoint code width.
- HOLD_CYCLES, 64, minimum cycles a granted code stays on io_out (>=1).

Ports:
- wb_clk_i  input  1  system clock.
- wb_rst_i  input  1  synchronous active-high reset.
- req_valid  input  NREQ  requester i has a code pending.
- req_code  input  NREQ*CODE_W  code of requester i at bits [i*CODE_W +: CODE_W].
- req_ready  output  NREQ  one-hot accept pulse; transfer occurs when valid&ready.
- la_ovr_en  input  1  LA override enable.
- la_ovr_code  input  CODE_W  LA override code.
- io_out  output  CODE_W  checkpoint code to pads (registered).
- io_oeb  output  CODE_W  pad output-enable bar (registered).
- busy  output  1  high while in HOLD.
- grant_id  output  3  index of the last granted requester.

Behaviour:
- Reset values: io_out=0, io_oeb=all 1, req_ready=0, busy=0, grant_id=0, rr pointer=0, state=IDLE, hold counter=0, last_code=0.
- io_oeb goes to all 0 on the first cycle after reset deasserts and stays 0.
- States:
  - IDLE: no code being held.
  - HOLD: a granted code is being held; counter cnt runs down.
  - OVR: LA override active; the previous state is remembered.
- IDLE to HOLD:
  - Trigger: any req_valid high and la_ovr_en low.
  - Pick: first valid index at or after ptr, wrapping NREQ-1 -> 0.
  - Same cycle: req_ready[g]=1 (combinational from registered state and req_valid).
  - Next edge: io_out=last_code=req_code[g], grant_id=g, ptr=(g+1) mod NREQ, cnt=HOLD_CYCLES-1, busy=1.
- Latency: a code presented in IDLE appears on io_out 1 cycle after acceptance.
- HOLD:
  - cnt decrements each cycle; req_ready=0 while cnt!=0.
  - At cnt==0 with a valid request: grant back-to-back in that cycle (no IDLE bubble), same rules as from IDLE.
  - At cnt==0 with no request: go to IDLE, busy=0, io_out keeps last_code.
- HOLD_CYCLES=1 allows one grant per cycle.
- Override:
  - la_ovr_en high in any state: enter OVR next edge; io_out=la_ovr_code (tracked every cycle while high); req_ready=0; cnt frozen; ptr frozen.
  - la_ovr_en falling: return to the saved state. io_out=last_code on the next edge; HOLD resumes with the frozen cnt.
  - Simultaneous override and grant-eligible request: override wins, no ready pulse, no transfer.
- req_ready is never asserted for an index whose req_valid is low; at most one bit is high.
- A requester that drops valid without ready loses nothing; no code is latched.
- Reset mid-HOLD or mid-OVR: all state returns to reset values in the next cycle. In-flight codes are discarded.
- NREQ not a power of two: ptr wraps by compare, never selects index >= NREQ.

Decomposition:
- Shared package la_chk_pkg: CODE_W default, state enum {IDLE, HOLD, OVR}, a function computing the counter width from HOLD_CYCLES.
- One sub-module rr_pick: combinational round-robin picker (inputs: valid vector, ptr; outputs: any, one-hot grant, index). Reusable by later LA/GPIO sharing blocks.

Test Plan:
- Reset then idle, no requests: io_out=0x0000, io_oeb=0xFFFF during reset, 0x0000 one cycle after release, busy=0.
- req0 posts 0xAB40, HOLD_CYCLES=64: ready pulse 1 cycle; io_out=0xAB40 next cycle; busy high exactly 64 cycles; grant_id=0.
- req0=0xAB41, req1=0xAB51, req2=0xAB60 all valid continuously, ptr=0: io_out sequence 0xAB41, 0xAB51, 0xAB60, 0xAB41, each held 64 cycles with no gap; ready pulses one-hot in order 0,1,2,0.
- Mid-HOLD, 10 cycles into a 0xAB41 hold: la_ovr_en=1, la_ovr_code=0xDEAD for 20 cycles. io_out=0xDEAD, no ready pulses. After release, io_out=0xAB41 and the remaining hold is 54 cycles.
- Override asserted in the same cycle req1 becomes valid in IDLE: req_ready stays 0; req1 is granted only after la_ovr_en drops.
- wb_rst_i pulsed for 1 cycle mid-HOLD with req3 pending: next cycle io_out=0, busy=0, ptr=0. With req0 and req3 both valid, req0 is granted first.

Source files
------------

// File: rtl/la_chk_pkg.sv
// -----------------------------------------------------------------------------
// la_chk_pkg
// Shared definitions for the checkpoint-bus sharing blocks.
//   CHK_CODE_W  : default checkpoint code width (pads mprj_io[31:16])
//   CHK_IDX_W   : width of a requester index (covers up to 8 requesters)
//   chk_state_e : arbiter state encoding (IDLE / HOLD / OVR)
//   chk_cnt_w() : width of a down-counter able to hold HOLD_CYCLES-1
// -----------------------------------------------------------------------------
package la_chk_pkg;

  localparam int CHK_CODE_W = 16;
  localparam int CHK_IDX_W  = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HOLD = 2'd1,
    ST_OVR  = 2'd2
  } chk_state_e;

  // Smallest width w (at least 1) with 2**w >= hold_cycles, so the
  // counter can be loaded with hold_cycles-1 without truncation.
  function automatic int chk_cnt_w(input int hold_cycles);
    int w;
    w = 1;
    while ((1 << w) < hold_cycles) begin
      w = w + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/la_checkpoint_arbiter_rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Combinational round-robin picker: returns the first valid index at or after
// ptr_i, wrapping N-1 -> 0. Wrap is done by compare/subtract so a non
// power-of-two N never yields an index >= N.
//   valid_i : request vector
//   ptr_i   : index with highest priority this cycle
//   any_o   : at least one request is valid
//   grant_o : one-hot grant (all zero when any_o is low)
//   idx_o   : binary index of the granted request
// -----------------------------------------------------------------------------
module rr_pick
  import la_chk_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0]           valid_i,
  input  logic [CHK_IDX_W-1:0]   ptr_i,
  output logic                   any_o,
  output logic [N-1:0]           grant_o,
  output logic [CHK_IDX_W-1:0]   idx_o
);

  logic [CHK_IDX_W:0] cand;
  logic [N-1:0]       rot;

  // Walk the candidates in priority order starting at the pointer and keep
  // the first one that is valid. Shifts are used instead of variable bit
  // selects so the index width never has to match N exactly.
  always_comb begin
    any_o   = 1'b0;
    grant_o = '0;
    idx_o   = '0;
    cand    = '0;
    rot     = '0;
    for (int k = 0; k < N; k++) begin
      cand = {1'b0, ptr_i} + (CHK_IDX_W + 1)'(k);
      if (cand >= (CHK_IDX_W + 1)'(N)) begin
        cand = cand - (CHK_IDX_W + 1)'(N);
      end
      rot = valid_i >> cand;
      if (!any_o && rot[0]) begin
        any_o   = 1'b1;
        grant_o = N'(1) << cand;
        idx_o   = cand[CHK_IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/la_checkpoint_arbiter.sv
// -----------------------------------------------------------------------------
// la_checkpoint_arbiter
// Shares the checkpoint pad bus between NREQ requesters. Requesters post codes
// with valid/ready; grants are round-robin and each granted code is held on
// the pads for at least HOLD_CYCLES cycles. The management SoC may override
// the pads through the LA probes; arbitration pauses while it does.
//   wb_clk_i, wb_rst_i    : clock, synchronous active-high reset
//   req_valid / req_code  : per-requester handshake and code
//   req_ready             : one-hot accept pulse (combinational)
//   la_ovr_en/la_ovr_code : LA override
//   io_out / io_oeb       : registered pad drive and output-enable bar
//   busy                  : high while a code is being held
//   grant_id              : index of the last granted requester
// -----------------------------------------------------------------------------
module la_checkpoint_arbiter
  import la_chk_pkg::*;
#(
  parameter int NREQ        = 4,
  parameter int CODE_W      = CHK_CODE_W,
  parameter int HOLD_CYCLES = 64
) (
  input  logic                     wb_clk_i,
  input  logic                     wb_rst_i,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ*CODE_W-1:0]   req_code,
  output logic [NREQ-1:0]          req_ready,
  input  logic                     la_ovr_en,
  input  logic [CODE_W-1:0]        la_ovr_code,
  output logic [CODE_W-1:0]        io_out,
  output logic [CODE_W-1:0]        io_oeb,
  output logic                     busy,
  output logic [CHK_IDX_W-1:0]     grant_id
);

  localparam int                   CNT_W    = chk_cnt_w(HOLD_CYCLES);
  localparam logic [CNT_W-1:0]     CNT_LOAD = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CHK_IDX_W-1:0] LAST_IDX = CHK_IDX_W'(NREQ - 1);

  chk_state_e             state_q, state_d;
  chk_state_e             saved_q, saved_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [CHK_IDX_W-1:0]   ptr_q, ptr_d;
  logic [CODE_W-1:0]      last_q, last_d;
  logic [CODE_W-1:0]      out_q, out_d;
  logic [CODE_W-1:0]      oeb_q;
  logic                   busy_q, busy_d;
  logic [CHK_IDX_W-1:0]   gid_q, gid_d;

  logic                   pick_any;
  logic [NREQ-1:0]        pick_grant;
  logic [CHK_IDX_W-1:0]   pick_idx;
  logic [CODE_W-1:0]      code_sel;
  logic                   can_grant;

  rr_pick #(
    .N (NREQ)
  ) u_pick (
    .valid_i (req_valid),
    .ptr_i   (ptr_q),
    .any_o   (pick_any),
    .grant_o (pick_grant),
    .idx_o   (pick_idx)
  );

  // A grant is only possible from IDLE or at the last cycle of a hold, and
  // the override always wins over a grant in the same cycle. The override
  // state itself never grants; it first returns to the state it paused.
  always_comb begin
    code_sel  = CODE_W'(req_code >> (int'(pick_idx) * CODE_W));
    can_grant = pick_any && !la_ovr_en &&
                ((state_q == ST_IDLE) ||
                 ((state_q == ST_HOLD) && (cnt_q == '0)));
    req_ready = can_grant ? pick_grant : '0;
  end

  // Next-state logic. Every register keeps its value by default; the pads
  // keep showing the last code after a hold runs out. While the override is
  // active the hold counter and pointer are left untouched so a paused hold
  // resumes exactly where it stopped.
  always_comb begin
    state_d = state_q;
    saved_d = saved_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    last_d  = last_q;
    out_d   = out_q;
    gid_d   = gid_q;

    if (la_ovr_en) begin
      state_d = ST_OVR;
      out_d   = la_ovr_code;
      if (state_q != ST_OVR) begin
        saved_d = state_q;
      end
    end else begin
      case (state_q)
        ST_IDLE, ST_HOLD: begin
          if (can_grant) begin
            state_d = ST_HOLD;
            cnt_d   = CNT_LOAD;
            last_d  = code_sel;
            out_d   = code_sel;
            gid_d   = pick_idx;
            ptr_d   = (pick_idx == LAST_IDX) ? '0 : pick_idx + 1'b1;
          end else if (state_q == ST_HOLD) begin
            if (cnt_q != '0) begin
              cnt_d = cnt_q - 1'b1;
            end else begin
              state_d = ST_IDLE;
            end
          end
        end
        ST_OVR: begin
          state_d = saved_q;
          out_d   = last_q;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end

    busy_d = (state_d == ST_HOLD);
  end

  // State register. The pad enables come up driven on the first cycle after
  // reset is released and stay driven from then on.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q <= ST_IDLE;
      saved_q <= ST_IDLE;
      cnt_q   <= '0;
      ptr_q   <= '0;
      last_q  <= '0;
      out_q   <= '0;
      oeb_q   <= '1;
      busy_q  <= 1'b0;
      gid_q   <= '0;
    end else begin
      state_q <= state_d;
      saved_q <= saved_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      last_q  <= last_d;
      out_q   <= out_d;
      oeb_q   <= '0;
      busy_q  <= busy_d;
      gid_q   <= gid_d;
    end
  end

  assign io_out   = out_q;
  assign io_oeb   = oeb_q;
  assign busy     = busy_q;
  assign grant_id = gid_q;

endmodule

// File: tb/tb_la_checkpoint_arbiter.sv
// -----------------------------------------------------------------------------
// tb_la_checkpoint_arbiter
// Self-checking bench: a table of single-cycle vectors, directed multi-cycle
// sequences and a randomized phase, all compared against a behavioural model
// that tracks "cycles of hold remaining" and a paused flag.
// -----------------------------------------------------------------------------
module tb_la_checkpoint_arbiter;

  localparam int NREQ   = 4;
  localparam int CODE_W = 16;
  localparam int HOLD   = 64;

  logic                   clock = 1'b0;
  logic                   reset;
  logic [NREQ-1:0]        reqValid;
  logic [NREQ*CODE_W-1:0] reqCode;
  logic [NREQ-1:0]        reqReady;
  logic                   ovrEn;
  logic [CODE_W-1:0]      ovrCode;
  logic [CODE_W-1:0]      ioOut;
  logic [CODE_W-1:0]      ioOeb;
  logic                   busy;
  logic [2:0]             grantId;

  int checkCount = 0;
  int errorCount = 0;

  // Behavioural model state
  bit                mHolding;
  bit                mInOvr;
  bit                mOeb;
  int                mRemain;
  int                mPtr;
  int                mGid;
  logic [CODE_W-1:0] mOut;
  logic [CODE_W-1:0] mLast;

  logic [NREQ-1:0]   lastReady;

  la_checkpoint_arbiter #(
    .NREQ        (NREQ),
    .CODE_W      (CODE_W),
    .HOLD_CYCLES (HOLD)
  ) dut (
    .wb_clk_i    (clock),
    .wb_rst_i    (reset),
    .req_valid   (reqValid),
    .req_code    (reqCode),
    .req_ready   (reqReady),
    .la_ovr_en   (ovrEn),
    .la_ovr_code (ovrCode),
    .io_out      (ioOut),
    .io_oeb      (ioOeb),
    .busy        (busy),
    .grant_id    (grantId)
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  always #5 clock = ~clock;

  // Hard time limit so the bench can never hang
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  typedef struct {
    logic              rst;
    logic [NREQ-1:0]   valid;
    logic              ovr;
    logic [CODE_W-1:0] ovrCode;
    logic [NREQ-1:0]   expReady;
    logic [CODE_W-1:0] expOut;
    logic [CODE_W-1:0] expOeb;
    logic              expBusy;
    logic [2:0]        expGid;
  } vec_t;

  vec_t vecs[13];

  // Compare one observed value with its expected value
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  // Drive one cycle of inputs away from the rising edge, then let them settle
  task automatic applyStimulus(input logic rst, input logic [NREQ-1:0] valid,
                               input logic [NREQ*CODE_W-1:0] codes,
                               input logic ovr, input logic [CODE_W-1:0] oCode);
    @(negedge clock);
    reset    = rst;
    reqValid = valid;
    reqCode  = codes;
    ovrEn    = ovr;
    ovrCode  = oCode;
    #1;
  endtask

  function automatic void modelReset();
    mHolding = 0;
    mInOvr   = 0;
    mOeb     = 1;
    mRemain  = 0;
    mPtr     = 0;
    mGid     = 0;
    mOut     = '0;
    mLast    = '0;
  endfunction

  // Who may be accepted this cycle: nobody while the LA owns the pads or a
  // hold still has more than its final cycle to run; otherwise the first
  // valid requester counting up from the pointer.
  function automatic logic [NREQ-1:0] modelReady(input logic [NREQ-1:0] valid,
                                                 input logic ovr);
    if (ovr || mInOvr) return '0;
    if (mHolding && mRemain != 1) return '0;
    for (int k = 0; k < NREQ; k++) begin
      if (valid[(mPtr + k) % NREQ]) return NREQ'(1) << ((mPtr + k) % NREQ);
    end
    return '0;
  endfunction

  function automatic int oneHotIdx(input logic [NREQ-1:0] v);
    for (int i = 0; i < NREQ; i++) begin
      if (v[i]) return i;
    end
    return -1;
  endfunction

  // Advance the model across one rising edge
  function automatic void modelStep(input logic rst, input logic [NREQ-1:0] valid,
                                    input logic [NREQ*CODE_W-1:0] codes,
                                    input logic ovr, input logic [CODE_W-1:0] oCode);
    logic [NREQ-1:0] rdy;
    int g;
    rdy = modelReady(valid, ovr);
    if (rst) begin
      modelReset();
      return;
    end
    mOeb = 0;
    if (ovr) begin
      mInOvr = 1;
      mOut   = oCode;
    end else if (mInOvr) begin
      mInOvr = 0;
      mOut   = mLast;
    end else if (rdy != '0) begin
      g        = oneHotIdx(rdy);
      mHolding = 1;
      mRemain  = HOLD;
      mLast    = CODE_W'(codes >> (g * CODE_W));
      mOut     = mLast;
      mGid     = g;
      mPtr     = (g + 1) % NREQ;
    end else if (mHolding) begin
      if (mRemain == 1) mHolding = 0;
      else mRemain = mRemain - 1;
    end
  endfunction

  // Compare every DUT output with the model for the current cycle
  task automatic checkModel();
    checkOutput("model ready", 32'(reqReady), 32'(modelReady(reqValid, ovrEn)));
    checkOutput("model io_out", 32'(ioOut), 32'(mOut));
    checkOutput("model busy", 32'(busy), 32'(mHolding && !mInOvr));
    checkOutput("model grant_id", 32'(grantId), 32'(mGid));
    checkOutput("model io_oeb", 32'(ioOeb), mOeb ? 32'h0000FFFF : 32'h0);
  endtask

  // One fully checked cycle
  task automatic runCycle(input logic rst, input logic [NREQ-1:0] valid,
                          input logic [NREQ*CODE_W-1:0] codes,
                          input logic ovr, input logic [CODE_W-1:0] oCode);
    applyStimulus(rst, valid, codes, ovr, oCode);
    checkModel();
    lastReady = reqReady;
    modelStep(rst, valid, codes, ovr, oCode);
  endtask

  // Main sequence: table, directed corners, random traffic
  initial begin
    logic [NREQ*CODE_W-1:0] tabCodes;
    logic [NREQ*CODE_W-1:0] codesA;
    logic [NREQ*CODE_W-1:0] codesB;
    logic [NREQ*CODE_W-1:0] rndCodes;
    int pulseIdx[$];
    int pulseCyc[$];
    int busyCount;
    int ovrPulses;
    int ovrLeft;
    bit seenBusy;
    bit found;

    reset    = 1'b1;
    reqValid = '0;
    reqCode  = '0;
    ovrEn    = 1'b0;
    ovrCode  = '0;
    modelReset();

    tabCodes = {16'hAB73, 16'hAB60, 16'hAB51, 16'hAB40};
    //            rst valid    ovr code     ready    out       oeb       busy gid
    vecs[0]  = '{1'b1, 4'b0000, 1'b0, 16'h0,    4'b0000, 16'h0000, 16'hFFFF, 1'b0, 3'd0};
    vecs[1]  = '{1'b0, 4'b0000, 1'b0, 16'h0,    4'b0000, 16'h0000, 16'hFFFF, 1'b0, 3'd0};
    vecs[2]  = '{1'b0, 4'b0000, 1'b0, 16'h0,    4'b0000, 16'h0000, 16'h0000, 1'b0, 3'd0};
    vecs[3]  = '{1'b0, 4'b0001, 1'b0, 16'h0,    4'b0001, 16'h0000, 16'h0000, 1'b0, 3'd0};
    vecs[4]  = '{1'b0, 4'b0000, 1'b0, 16'h0,    4'b0000, 16'hAB40, 16'h0000, 1'b1, 3'd0};
    vecs[5]  = '{1'b0, 4'b0010, 1'b0, 16'h0,    4'b0000, 16'hAB40, 16'h0000, 1'b1, 3'd0};
    vecs[6]  = '{1'b0, 4'b0010, 1'b1, 16'hDEAD, 4'b0000, 16'hAB40, 16'h0000, 1'b1, 3'd0};
    vecs[7]  = '{1'b0, 4'b0010, 1'b1, 16'hDEAD, 4'b0000, 16'hDEAD, 16'h0000, 1'b0, 3'd0};
    vecs[8]  = '{1'b0, 4'b0010, 1'b0, 16'h0,    4'b0000, 16'hDEAD, 16'h0000, 1'b0, 3'd0};
    vecs[9]  = '{1'b0, 4'b0010, 1'b0, 16'h0,    4'b0000, 16'hAB40, 16'h0000, 1'b1, 3'd0};
    vecs[10] = '{1'b1, 4'b0010, 1'b0, 16'h0,    4'b0000, 16'hAB40, 16'h0000, 1'b1, 3'd0};
    vecs[11] = '{1'b0, 4'b1001, 1'b0, 16'h0,    4'b0001, 16'h0000, 16'hFFFF, 1'b0, 3'd0};
    vecs[12] = '{1'b0, 4'b1000, 1'b0, 16'h0,    4'b0000, 16'hAB40, 16'h0000, 1'b1, 3'd0};

    for (int i = 0; i < 13; i++) begin
      applyStimulus(vecs[i].rst, vecs[i].valid, tabCodes, vecs[i].ovr, vecs[i].ovrCode);
      checkOutput($sformatf("row%0d ready", i), 32'(reqReady), 32'(vecs[i].expReady));
      checkOutput($sformatf("row%0d io_out", i), 32'(ioOut), 32'(vecs[i].expOut));
      checkOutput($sformatf("row%0d io_oeb", i), 32'(ioOeb), 32'(vecs[i].expOeb));
      checkOutput($sformatf("row%0d busy", i), 32'(busy), 32'(vecs[i].expBusy));
      checkOutput($sformatf("row%0d grant_id", i), 32'(grantId), 32'(vecs[i].expGid));
      modelStep(vecs[i].rst, vecs[i].valid, tabCodes, vecs[i].ovr, vecs[i].ovrCode);
    end

    // Three requesters held valid: back-to-back grants 0,1,2,0 every HOLD cycles
    codesA = {16'h0000, 16'hAB60, 16'hAB51, 16'hAB41};
    runCycle(1'b1, '0, codesA, 1'b0, '0);
    for (int c = 0; c < 4 * HOLD + 5; c++) begin
      runCycle(1'b0, 4'b0111, codesA, 1'b0, '0);
      if (lastReady != '0) begin
        pulseIdx.push_back(oneHotIdx(lastReady));
        pulseCyc.push_back(c);
      end
    end
    checkOutput("rr pulse count", 32'(pulseIdx.size()), 32'd5);
    if (pulseIdx.size() >= 4) begin
      checkOutput("rr order 0", 32'(pulseIdx[0]), 32'd0);
      checkOutput("rr order 1", 32'(pulseIdx[1]), 32'd1);
      checkOutput("rr order 2", 32'(pulseIdx[2]), 32'd2);
      checkOutput("rr order 3", 32'(pulseIdx[3]), 32'd0);
      for (int p = 1; p < 4; p++) begin
        checkOutput($sformatf("rr gap %0d", p), 32'(pulseCyc[p] - pulseCyc[p-1]), 32'(HOLD));
      end
    end

    // Override 10 cycles into a hold; the rest of the hold resumes afterwards
    codesB = {16'h0000, 16'h0000, 16'hAB52, 16'hAB41};
    runCycle(1'b1, '0, codesB, 1'b0, '0);
    runCycle(1'b0, 4'b0001, codesB, 1'b0, '0);
    checkOutput("ovr hold grant", 32'(lastReady), 32'b0001);
    repeat (10) runCycle(1'b0, '0, codesB, 1'b0, '0);
    ovrPulses = 0;
    for (int c = 0; c < 20; c++) begin
      runCycle(1'b0, 4'b0010, codesB, 1'b1, 16'hDEAD);
      if (lastReady != '0) ovrPulses++;
      if (c == 5) checkOutput("ovr io_out", 32'(ioOut), 32'hDEAD);
    end
    checkOutput("ovr ready pulses", 32'(ovrPulses), 32'd0);
    busyCount = 0;
    seenBusy  = 0;
    for (int c = 0; c < 200; c++) begin
      runCycle(1'b0, '0, codesB, 1'b0, '0);
      if (busy) begin
        if (!seenBusy) checkOutput("ovr resume io_out", 32'(ioOut), 32'hAB41);
        seenBusy = 1;
        busyCount++;
      end else if (seenBusy) begin
        break;
      end
    end
    checkOutput("ovr remaining hold", 32'(busyCount), 32'd54);

    // Override raised in the same cycle req1 appears in IDLE
    runCycle(1'b1, '0, codesB, 1'b0, '0);
    runCycle(1'b0, 4'b0010, codesB, 1'b1, 16'hBEEF);
    checkOutput("ovr vs req ready", 32'(lastReady), 32'd0);
    repeat (3) runCycle(1'b0, 4'b0010, codesB, 1'b1, 16'hBEEF);
    found = 0;
    for (int c = 0; c < 6; c++) begin
      runCycle(1'b0, 4'b0010, codesB, 1'b0, '0);
      if (lastReady != '0) begin
        found = 1;
        checkOutput("post ovr grant", 32'(lastReady), 32'b0010);
        break;
      end
    end
    checkOutput("post ovr grant seen", 32'(found), 32'd1);

    // Reset mid-hold with req3 pending: pointer returns to 0
    runCycle(1'b1, '0, tabCodes, 1'b0, '0);
    runCycle(1'b0, 4'b0001, tabCodes, 1'b0, '0);
    repeat (5) runCycle(1'b0, 4'b1000, tabCodes, 1'b0, '0);
    runCycle(1'b1, 4'b1000, tabCodes, 1'b0, '0);
    runCycle(1'b0, 4'b1001, tabCodes, 1'b0, '0);
    checkOutput("rst io_out", 32'(ioOut), 32'h0);
    checkOutput("rst busy", 32'(busy), 32'd0);
    checkOutput("rst first grant", 32'(lastReady), 32'b0001);
    runCycle(1'b0, '0, tabCodes, 1'b0, '0);
    checkOutput("rst grant code", 32'(ioOut), 32'hAB40);

    // Random traffic against the model
    ovrLeft = 0;
    for (int c = 0; c < 3000; c++) begin
      logic rRst;
      logic rOvr;
      rRst = ($urandom_range(0, 499) == 0);
      if (ovrLeft > 0) ovrLeft--;
      else if ($urandom_range(0, 59) == 0) ovrLeft = $urandom_range(1, 15);
      rOvr = (ovrLeft > 0);
      rndCodes = {$urandom(), $urandom()};
      runCycle(rRst, NREQ'($urandom()), rndCodes, rOvr, CODE_W'($urandom()));
    end

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
